// File: rtl/l2_arbiter_rr.sv
// N-channel arbiter in front of the shared L2: registers one granted request,
// holds it on the L2 port until l2_resp, then pulses ch_resp to the winner.
module l2_arbiter_rr #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int BLOCK_W = 128,
    parameter int RR_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_read,
    input  logic [NUM_CH-1:0]         ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_address,
    input  logic [NUM_CH*BLOCK_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]         ch_resp,
    output logic [BLOCK_W-1:0]        ch_rdata,
    output logic                      l2_read,
    output logic                      l2_write,
    output logic [ADDR_W-1:0]         l2_address,
    output logic [BLOCK_W-1:0]        l2_wdata,
    input  logic                      l2_resp,
    input  logic [BLOCK_W-1:0]        l2_rdata,
    output logic                      quiet
);

    // state | meaning
    // IDLE  | no transaction; arbitrate among requesting channels
    // BUSY  | latched request driven on the L2 port, waiting for l2_resp
    // RESP  | one-cycle ch_resp pulse to the granted channel
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       gnt_q, gnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLOCK_W-1:0]  wdata_q, wdata_d;
    logic [BLOCK_W-1:0]  rdata_q, rdata_d;

    logic [NUM_CH-1:0]   req;
    logic                any_req;
    logic [GW-1:0]       cand;
    logic [GW-1:0]       win;
    logic                found;

    assign req     = ch_read | ch_write;
    assign any_req = |req;

    // Search starts just after the last winner in round-robin mode, at 0 otherwise.
    always_comb begin
        cand  = '0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                cand = GW'((int'(ptr_q) + 1 + k) % NUM_CH);
            end else begin
                cand = GW'(k);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = win;
                    ptr_d   = win;
                    op_wr_d = ch_write[win];
                    addr_d  = ch_address[int'(win)*ADDR_W +: ADDR_W];
                    wdata_d = ch_wdata[int'(win)*BLOCK_W +: BLOCK_W];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (l2_resp) begin
                    rdata_d = l2_rdata;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NUM_CH - 1);
            gnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // L2 side is purely state-decoded from registers; no path from ch_* inputs.
    assign l2_read    = (state_q == BUSY) & ~op_wr_q;
    assign l2_write   = (state_q == BUSY) &  op_wr_q;
    assign l2_address = addr_q;
    assign l2_wdata   = wdata_q;
    assign ch_rdata   = rdata_q;
    assign quiet      = (state_q == IDLE) & ~any_req;

    always_comb begin
        ch_resp = '0;
        if (state_q == RESP) begin
            ch_resp[gnt_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_arbiter_rr.sv
// Drives a round-robin and a fixed-priority arbiter with random traffic and
// compares both against a transaction-level reference model every cycle.
module tb_l2_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int BW = 64;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    rd [2];
    logic [N-1:0]    wr [2];
    logic [N-1:0]    resp [2];
    logic [N*AW-1:0] addr [2];
    logic [N*BW-1:0] wdat [2];
    logic [BW-1:0]   crd [2];
    logic [BW-1:0]   l2wd [2];
    logic [BW-1:0]   l2rd [2];
    logic [AW-1:0]   l2a [2];
    logic            l2r [2];
    logic            l2w [2];
    logic            l2resp [2];
    logic            quiet [2];

    int n_cmp = 0;
    int n_err = 0;
    int n_resets = 0;

    // Reference model: 0 = idle, 1 = request on L2, 2 = response cycle
    int            m_phase [2];
    int            m_gnt [2];
    int            m_last [2];
    logic          m_wr [2];
    logic [AW-1:0] m_addr [2];
    logic [BW-1:0] m_wdata [2];
    logic [BW-1:0] m_rdata [2];

    always #5 clk = ~clk;

    l2_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .ch_read(rd[0]), .ch_write(wr[0]), .ch_address(addr[0]), .ch_wdata(wdat[0]),
        .ch_resp(resp[0]), .ch_rdata(crd[0]),
        .l2_read(l2r[0]), .l2_write(l2w[0]), .l2_address(l2a[0]), .l2_wdata(l2wd[0]),
        .l2_resp(l2resp[0]), .l2_rdata(l2rd[0]), .quiet(quiet[0])
    );

    l2_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .BLOCK_W(BW), .RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .ch_read(rd[1]), .ch_write(wr[1]), .ch_address(addr[1]), .ch_wdata(wdat[1]),
        .ch_resp(resp[1]), .ch_rdata(crd[1]),
        .l2_read(l2r[1]), .l2_write(l2w[1]), .l2_address(l2a[1]), .l2_wdata(l2wd[1]),
        .l2_resp(l2resp[1]), .l2_rdata(l2rd[1]), .quiet(quiet[1])
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_gnt[d]   = 0;
            m_last[d]  = N - 1;
            m_wr[d]    = 1'b0;
            m_addr[d]  = '0;
            m_wdata[d] = '0;
            m_rdata[d] = '0;
        end
    endtask

    // Round-robin: the requester closest after the last winner (circular
    // distance); fixed priority: the lowest requesting index.
    function automatic int pick(input int d);
        int best = -1;
        int best_key = N;
        int key;
        for (int i = 0; i < N; i++) begin
            if (rd[d][i] | wr[d][i]) begin
                key = (d == 0) ? ((i - m_last[d] - 1 + 2 * N) % N) : i;
                if (key < best_key) begin
                    best_key = key;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_step(input int d);
        int w;
        case (m_phase[d])
            0: begin
                w = pick(d);
                if (w >= 0) begin
                    m_gnt[d]   = w;
                    m_last[d]  = w;
                    m_wr[d]    = wr[d][w];
                    m_addr[d]  = addr[d][w*AW +: AW];
                    m_wdata[d] = wdat[d][w*BW +: BW];
                    m_phase[d] = 1;
                end
            end
            1: begin
                if (l2resp[d]) begin
                    m_rdata[d] = l2rd[d];
                    m_phase[d] = 2;
                end
            end
            default: m_phase[d] = 0;
        endcase
    endtask

    task automatic check_outputs(input int d);
        logic [N-1:0] exp_resp;
        exp_resp = '0;
        if (m_phase[d] == 2) exp_resp[m_gnt[d]] = 1'b1;
        check_eq(d == 0 ? "rr l2_read" : "fp l2_read", l2r[d], (m_phase[d] == 1) && !m_wr[d]);
        check_eq(d == 0 ? "rr l2_write" : "fp l2_write", l2w[d], (m_phase[d] == 1) && m_wr[d]);
        check_eq(d == 0 ? "rr ch_resp" : "fp ch_resp", resp[d], exp_resp);
        if (m_phase[d] == 1) begin
            check_eq(d == 0 ? "rr l2_address" : "fp l2_address", l2a[d], m_addr[d]);
            check_eq(d == 0 ? "rr l2_wdata" : "fp l2_wdata", l2wd[d], m_wdata[d]);
        end
        if (m_phase[d] == 2 && !m_wr[d])
            check_eq(d == 0 ? "rr ch_rdata" : "fp ch_rdata", crd[d], m_rdata[d]);
    endtask

    task automatic drive(input int d);
        int op;
        for (int i = 0; i < N; i++) begin
            if (resp[d][i]) begin
                rd[d][i] = 1'b0;
                wr[d][i] = 1'b0;
            end else if (!(rd[d][i] | wr[d][i]) && $urandom_range(0, 9) < ((i == 0) ? 6 : 3)) begin
                op = $urandom_range(1, 3);
                rd[d][i] = op[0];
                wr[d][i] = op[1];
            end
            addr[d][i*AW +: AW] = AW'($urandom);
            wdat[d][i*BW +: BW] = {$urandom, $urandom};
        end
        l2resp[d] = (m_phase[d] == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        l2rd[d]   = {$urandom, $urandom};
    endtask

    task automatic check_quiet(input int d);
        check_eq(d == 0 ? "rr quiet" : "fp quiet", quiet[d], (m_phase[d] == 0) && ((rd[d] | wr[d]) == '0));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd[d] = '0; wr[d] = '0; addr[d] = '0; wdat[d] = '0;
            l2resp[d] = 1'b0; l2rd[d] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("reset l2_read", l2r[d], 1'b0);
            check_eq("reset l2_write", l2w[d], 1'b0);
            check_eq("reset ch_resp", resp[d], '0);
            check_eq("reset l2_address", l2a[d], '0);
            check_eq("reset ch_rdata", crd[d], '0);
            check_eq("reset quiet", quiet[d], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Every channel requests at once: ptr starts at N-1, so channel 0 wins first.
        for (int d = 0; d < 2; d++) begin
            rd[d] = '1;
            addr[d] = {$urandom, $urandom};
            wdat[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) model_step(d);
            if (c == 0) check_eq("first grant ch0", l2a[0], addr[0][AW-1:0]);
            for (int d = 0; d < 2; d++) check_outputs(d);
            if (c >= 1000 * (n_resets + 1) && m_phase[0] == 1) begin
                rst_n = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    check_eq("midreset l2_read", l2r[d], 1'b0);
                    check_eq("midreset l2_write", l2w[d], 1'b0);
                    check_eq("midreset ch_resp", resp[d], '0);
                end
                model_reset();
                n_resets++;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int d = 0; d < 2; d++) drive(d);
            #1;
            for (int d = 0; d < 2; d++) check_quiet(d);
        end
        check_eq("mid-transaction resets", n_resets >= 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_arbiter_rr.md
# l2_arbiter_rr

Parametrised N-channel arbiter between the L1 caches (and any future L2 clients such as a prefetcher or victim buffer) and the shared L2 cache. It generalises the fixed two-client I/D arbiter to `NUM_CH` requesters and selectable fixed-priority or round-robin grant. It registers the granted request, holds it stable on the L2 port until `l2_resp`, then returns a one-cycle response to the winning channel. A `quiet` output tells the pipeline when no memory traffic is pending or in flight.

## Interface
- `NUM_CH`, default 2: number of requester channels, ≥2. Channel 0 is the icache and channel 1 the dcache by convention.
- `ADDR_W`, default 16: byte address width.
- `BLOCK_W`, default 128: cache block width.
- `RR_MODE`, default 1: 1 selects round-robin grant; 0 selects fixed priority, lowest index wins.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_read`  in  NUM_CH  per-channel read request, level; held until that channel's `ch_resp`.
- `ch_write`  in  NUM_CH  per-channel write request, level; held until that channel's `ch_resp`.
- `ch_address`  in  NUM_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
- `ch_wdata`  in  NUM_CH*BLOCK_W  packed write blocks, same packing as `ch_address`.
- `ch_resp`  out  NUM_CH  one-hot, one-cycle completion pulse.
- `ch_rdata`  out  BLOCK_W  read block, broadcast to all channels; valid while `ch_resp` is high.
- `l2_read`, `l2_write`  out  1 each  L2 request, level.
- `l2_address`  out  ADDR_W  L2 address.
- `l2_wdata`  out  BLOCK_W  L2 write block.
- `l2_resp`  in  1  L2 completion.
- `l2_rdata`  in  BLOCK_W  L2 read block; valid with `l2_resp`.
- `quiet`  out  1  high when the arbiter is in IDLE and no channel is requesting.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE.** A channel is *requesting* when `ch_read[i] | ch_write[i]`. If any channel is requesting, compute the winner, then:
  - latch `gnt` (a `$clog2(NUM_CH)`-bit index);
  - latch the winner's address and wdata;
  - latch op: write if `ch_write[i]`, otherwise read. Write wins if both are high on one channel; the read is dropped.
  - go to BUSY.
- **Grant, `RR_MODE=1`:** search indices `ptr+1, ptr+2, …` modulo `NUM_CH`; the first requesting index wins. `ptr` is updated to `gnt` on each grant.
- **Grant, `RR_MODE=0`:** the lowest requesting index wins; `ptr` is unused.
- **BUSY.**
  - `l2_read`/`l2_write` are driven from the latched op; `l2_address`/`l2_wdata` from the latched copies. Later changes on the channel inputs have no effect.
  - On `l2_resp`: capture `l2_rdata` and go to RESP.
- **RESP.**
  - `l2_read` = `l2_write` = 0.
  - `ch_resp[gnt]` = 1 and `ch_rdata` = captured block.
  - Go to IDLE unconditionally. Because of this cycle, a requester that drops its request on `ch_resp` is never re-granted spuriously.
- **`ch_rdata` on writes:** after a write, `ch_rdata` holds the last captured value; it is don't-care.
- **`quiet`:** combinational, `(state==IDLE) & ~|(ch_read|ch_write)`. It replaces `ld_regs` for pipeline-latch gating.
- **Reset values:**
  - state = IDLE; `ptr` = NUM_CH-1, so channel 0 is first after reset;
  - `gnt` = 0, latched address/wdata/rdata = 0;
  - all `ch_resp`, `l2_read`, `l2_write` = 0;
  - `quiet` follows its equation.
- **Reset mid-transaction:** outputs drop immediately (asynchronous), with no `ch_resp` for the aborted request. The L2 is reset on the same `rst_n`.
- `l2_resp` in IDLE or RESP is ignored.

## Timing
- Request seen high in IDLE at cycle t → `l2_*` asserted from cycle t+1.
- `l2_resp` high at cycle k (k ≥ t+1) → `ch_resp` high in cycle k+1 only → IDLE at k+2.
- The earliest next grant is made in cycle k+2, and its `l2_*` is asserted at k+3.
- Minimum occupancy is 3 cycles per transaction; there is no pipelining or overlap.
- `l2_*` outputs are registered or state-decoded: no combinational path from `ch_*` inputs to `l2_*`.
- The only combinational input→output path is `ch_read`/`ch_write` → `quiet`.

## Test plan
- **Single read, N=2:** ch0 reads 0x1230, `l2_resp` 2 cycles after `l2_read`, data 0xA5…A5 → `l2_address`=0x1230; `ch_resp`=2'b01 for exactly 1 cycle carrying 0xA5…A5; `quiet` high next cycle.
- **Round-robin, N=2:** ch0 and ch1 both hold reads continuously → grants go 0,1,0,1. Each `ch_resp` pulses once per grant, and no channel is granted twice in a row.
- **Fixed priority, `RR_MODE=0`:** same stimulus as round-robin → ch0 is granted every time and ch1 is never granted while ch0 requests. Once ch0 drops, ch1 is granted at the next IDLE.
- **Write, N=3 with wrap-around:** ch2 writes 0x00FE with wdata 0x1111…; ch0 then requests while BUSY →
  - `l2_write`=1, `l2_wdata`=0x1111…, `l2_address`=0x00FE held constant while ch2's inputs toggle;
  - `ch_resp`=3'b100;
  - ch0 granted next, wrapping from `ptr`=2.
- **Read+write conflict:** ch1 asserts read and write together → a single `l2_write` transaction and one `ch_resp[1]`.
- **Reset mid-BUSY:** drop `rst_n` two cycles into a read → `l2_read`=0 immediately, no `ch_resp`, state IDLE. After release with ch1 requesting, ch0 has priority again (`ptr`=NUM_CH-1), so ch1 is granted.
